// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and sram port bundle for sram_port_arbiter
// The lock vector exists only when ARB_LOCK_EN is defined.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]            lock;
`endif
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          sram_cs;
    logic                          sram_we;
    logic [ADDR_WIDTH-1:0]         sram_addr;
    logic [DATA_WIDTH-1:0]         sram_din;
    logic [DATA_WIDTH-1:0]         sram_dout;

`ifdef ARB_LOCK_EN
    modport slave (
        input  req, wr, addr, wdata, lock, sram_dout,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din
    );
    modport master (
        output req, wr, addr, wdata, lock, sram_dout,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din
    );
`else
    modport slave (
        input  req, wr, addr, wdata, sram_dout,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din
    );
    modport master (
        output req, wr, addr, wdata, sram_dout,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_din
    );
`endif
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one single-port sram
// Optional grant locking with bounded hold is enabled by defining ARB_LOCK_EN.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int HOLD_MAX   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_port_arbiter_if.slave bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 1) begin : g_bad_cfg
            $error("sram_port_arbiter: NUM_REQ must be 2..8 and HOLD_MAX >= 1");
        end
    endgenerate

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0]    gnt_raw;
    logic [NUM_REQ-1:0]    grant;
    logic                  rr_found;
    logic [PTR_W-1:0]      rr_idx;
    logic [PTR_W-1:0]      rr_next;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;

    // First requester at or above ptr, wrapping past the top index.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign rr_next = (rr_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rr_idx + PTR_W'(1);

`ifdef ARB_LOCK_EN
    typedef enum logic {ST_RR, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              others_pending;
    logic              stay_locked;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        hold_d         = hold_q;
        ptr_d          = ptr_q;
        gnt_raw        = '0;
        others_pending = |(bus.req & ~(NUM_REQ'(1) << owner_q));
        stay_locked    = (state_q == ST_LOCKED) && bus.req[owner_q] && bus.lock[owner_q]
                         && !((hold_q == HOLD_W'(HOLD_MAX)) && others_pending);
        if (stay_locked) begin
            // ptr already sits just past the owner, so exit resumes from there.
            gnt_raw[owner_q] = 1'b1;
            if (hold_q != HOLD_W'(HOLD_MAX)) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            state_d = ST_RR;
            if (rr_found) begin
                gnt_raw[rr_idx] = 1'b1;
                ptr_d           = rr_next;
                if (bus.lock[rr_idx]) begin
                    state_d = ST_LOCKED;
                    owner_d = rr_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RR;
            owner_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end
`else
    always_comb begin
        ptr_d   = ptr_q;
        gnt_raw = '0;
        if (rr_found) begin
            gnt_raw[rr_idx] = 1'b1;
            ptr_d           = rr_next;
        end
    end
`endif

    assign grant    = rst_n ? gnt_raw : '0;
    assign rvalid_d = grant & ~bus.wr;

    always_comb begin
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sram_we   = bus.wr[i];
                sram_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sram_din  = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt       = grant;
    assign bus.sram_cs   = |grant;
    assign bus.sram_we   = sram_we;
    assign bus.sram_addr = sram_addr;
    assign bus.sram_din  = sram_din;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.sram_dout;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized and directed bench for sram_port_arbiter
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_sram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int HM = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Write-first synchronous sram behind the arbiter.
    logic [DW-1:0] sram_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) begin
                sram_mem[bus.sram_addr] <= bus.sram_din;
                bus.sram_dout           <= bus.sram_din;
            end else begin
                bus.sram_dout <= sram_mem[bus.sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: rotating priority list, memory image and pending read.
    int            m_ptr = 0;
    logic [N-1:0]  m_rv = '0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_mem [16] = '{default: '0};
    bit            m_locked = 0;
    int            m_owner = 0;
    int            m_hold = 0;

    function automatic int pick(input logic [N-1:0] r);
        int order[$];
        int w;
        w = -1;
        for (int k = m_ptr; k < N; k++) order.push_back(k);
        for (int k = 0; k < m_ptr; k++) order.push_back(k);
        foreach (order[q]) if (w < 0 && r[order[q]]) w = order[q];
        return w;
    endfunction

    always @(negedge clk) begin : cmp
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        if (!rst_n) begin
            chk("rst_gnt", bus.gnt, '0);
            chk("rst_cs", bus.sram_cs, '0);
            chk("rst_rvalid", bus.rvalid, '0);
            m_ptr = 0; m_rv = '0; m_locked = 0; m_hold = 0;
        end else begin
            chk("rvalid", bus.rvalid, m_rv);
            if (m_rv != '0) chk("rdata", bus.rdata, m_rd);
            w = -1;
`ifdef ARB_LOCK_EN
            if (m_locked && bus.req[m_owner] && bus.lock[m_owner]
                && !(m_hold >= HM && (bus.req & ~(N'(1) << m_owner)) != '0)) begin
                w = m_owner;
                m_hold++;
            end else begin
                m_locked = 0;
                w = pick(bus.req);
                if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                    if (bus.lock[w]) begin
                        m_locked = 1; m_owner = w; m_hold = 1;
                    end
                end
            end
`else
            w = pick(bus.req);
            if (w >= 0) m_ptr = (w + 1) % N;
`endif
            eg = (w >= 0) ? (N'(1) << w) : '0;
            ea = (w >= 0) ? bus.addr[w*AW +: AW] : '0;
            chk("gnt", bus.gnt, eg);
            chk("sram_cs", bus.sram_cs, (w >= 0));
            chk("sram_we", bus.sram_we, (w >= 0) ? bus.wr[w] : 1'b0);
            chk("sram_addr", bus.sram_addr, ea);
            chk("sram_din", bus.sram_din, (w >= 0) ? bus.wdata[w*DW +: DW] : '0);
            m_rv = '0;
            if (w >= 0) begin
                if (bus.wr[w]) begin
                    m_mem[ea] = bus.wdata[w*DW +: DW];
                end else begin
                    m_rv = eg;
                    m_rd = m_mem[ea];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look(input string nm, input logic [N-1:0] eg, input logic [N-1:0] erv);
        @(negedge clk);
        #1;
        chk({nm, "_gnt"}, bus.gnt, eg);
        chk({nm, "_rvalid"}, bus.rvalid, erv);
    endtask

    task automatic lookg(input string nm, input logic [N-1:0] eg);
        @(negedge clk);
        #1;
        chk({nm, "_gnt"}, bus.gnt, eg);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.req   = 3'b111;
        bus.wr    = '0;
        bus.addr  = {4'd2, 4'd1, 4'd0};
        bus.wdata = '0;
`ifdef ARB_LOCK_EN
        bus.lock  = '0;
`endif
        look("reset", 3'b000, 3'b000);
        chk("reset_cs", bus.sram_cs, 1'b0);
        tick();
        rst_n = 1'b1;
        look("rot0", 3'b001, 3'b000); tick();
        look("rot1", 3'b010, 3'b001); tick();
        look("rot2", 3'b100, 3'b010); tick();
        look("rot3", 3'b001, 3'b100); tick();

        bus.req = 3'b010;
        look("toptr2", 3'b010, 3'b001); tick();
        bus.req = 3'b011;
        look("wrap0", 3'b001, 3'b010); tick();
        look("wrap1", 3'b010, 3'b001); tick();

        bus.req   = 3'b010;
        bus.wr    = 3'b010;
        bus.addr  = {4'd5, 4'd5, 4'd5};
        bus.wdata = {8'h00, 8'hA5, 8'h00};
        look("wr", 3'b010, 3'b010); tick();
        bus.req = 3'b100;
        bus.wr  = 3'b000;
        look("raw", 3'b100, 3'b000); tick();
        bus.req = 3'b000;
        look("raw_rv", 3'b000, 3'b100);
        chk("raw_rdata", bus.rdata, 8'hA5);
        tick();

        bus.req = 3'b001;
        look("mr", 3'b001, 3'b000);
        #2 rst_n = 1'b0;
        look("mr_rst", 3'b000, 3'b000);
        tick();
        rst_n   = 1'b1;
        bus.req = 3'b000;
        look("mr_rel", 3'b000, 3'b000);
        tick();

        for (int i = 0; i < 1500; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            bus.req = N'($urandom);
            bus.wr  = N'($urandom);
            for (int j = 0; j < N; j++) bus.addr[j*AW +: AW] = AW'($urandom_range(0, 3));
            bus.wdata = (N*DW)'($urandom);
`ifdef ARB_LOCK_EN
            bus.lock = N'($urandom);
`endif
            tick();
        end

`ifdef ARB_LOCK_EN
        rst_n   = 1'b0;
        bus.req = '0;
        bus.lock = '0;
        bus.wr  = '0;
        tick();
        rst_n    = 1'b1;
        bus.req  = 3'b011;
        bus.lock = 3'b001;
        for (int k = 0; k < HM; k++) begin
            lookg("lk_hold", 3'b001); tick();
        end
        lookg("lk_pass", 3'b010); tick();
        bus.req = 3'b001;
        for (int k = 0; k < 2 * HM; k++) begin
            lookg("lk_cont", 3'b001); tick();
        end
`endif
        bus.req = '0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
